reg_bank: RTL and testbench
===========================

# reg_bank

Architectural register file for the multicycle MIPS datapath, sitting directly downstream of the write-register select mux. That mux delivers a 32-bit write address of rs/rt/rd, 29 ($sp) or 31 ($ra); this block consumes it, stores the write-back data, and presents the two source operands through built-in A/B operand latches that the ALU stage reads. Writes, operand latching and same-cycle forwarding are all synchronous to one clock.

## Interface
- NUM_REGS, 32, number of architectural registers; addresses are 5 bits.
- SP_RESET, 32'd227, reset value of register 29 ($sp).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low: asserted at 0, clears state immediately, released synchronously by the system.
- reg_write  in  1  write enable for the write port.
- write_reg  in  32  write address from the select mux; only bits [4:0] address a register.
- write_data  in  32  write-back value.
- read_reg1  in  5  rs address.
- read_reg2  in  5  rt address.
- load_ab  in  1  capture the operands into the A/B latches.
- a_out  out  32  latched operand 1.
- b_out  out  32  latched operand 2.
- addr_err  out  1  sticky flag: a write was attempted with write_reg[31:5] nonzero.

## Operation
- Storage: 32 x 32-bit registers. Register 0 always reads 0 and is never written.
- Write: on a rising edge with reg_write=1, write_reg[31:5]==0 and write_reg[4:0]!=0, reg[write_reg[4:0]] <= write_data.
- Bad address: when reg_write=1 and write_reg[31:5]!=0, no register changes and addr_err <= 1. addr_err stays at 1 until reset.
- Write to register 0: silently dropped. It does not set addr_err.
- Operand latch: on a rising edge with load_ab=1, a_out <= value(read_reg1) and b_out <= value(read_reg2). With load_ab=0, a_out and b_out hold.
- value(r) definition:
  - 0 if r==0;
  - write_data if a valid write to r happens on the same edge (forwarding);
  - otherwise reg[r].
- Forwarding applies to both ports at once, so read_reg1==read_reg2==write target forwards to both.
- A dropped write (bad address, or register 0) never forwards.
- Reset (reset=0): asynchronously sets every register to 0 except reg[29]=SP_RESET. Also clears a_out=0, b_out=0, addr_err=0.
- While reset=0, all writes and latches are ignored.

## Timing
- Write latency: 1 edge. Data written at edge N is visible through a normal (non-forwarded) latch at edge N+1, and through forwarding at edge N itself.
- Operand latency: a_out/b_out are valid after the edge on which load_ab=1. There is no combinational path from any input to any output.
- Reset asserted mid-operation: takes effect immediately, not waiting for an edge.
  - An edge coinciding with reset low performs nothing.
  - The first edge after reset returns to 1 operates normally.
- Simultaneous reg_write and load_ab on the same edge: both happen, following the forwarding rules above.
- Address wrap: none. Indices 0..31 only. Upper bits are checked, never truncated silently.

## Test plan
- Reset: drive reset=0 mid-cycle, then load_ab=1 with read_reg1=29, read_reg2=5 -> a_out=227, b_out=0, addr_err=0. Outputs must read 0 immediately on assertion, before any edge.
- Write then read: write write_reg=31, data 0x0000_1234; next edge load_ab with read_reg1=31 -> a_out=0x0000_1234.
- Same-edge forwarding: reg_write=1, write_reg=8, data 0xDEAD_BEEF, with load_ab=1, read_reg1=8, read_reg2=8 on the same edge -> a_out=b_out=0xDEAD_BEEF.
- Register 0: write write_reg=0, data 0xFFFF_FFFF with same-edge load of read_reg1=0 -> a_out=0. A later read also gives 0. addr_err stays 0.
- Bad address: write_reg=32'h0000_0020, data 7 -> no register changes (reg[0] and reg[31] unchanged) and addr_err=1. addr_err holds through later valid writes and clears only on reset.
- Hold: load_ab=0 while reg 3 is rewritten -> a_out keeps its previous value until the next load_ab=1.

Source files
------------

// File: rtl/reg_bank.sv
// Architectural register file with built-in A/B operand latches and same-edge
// write forwarding. Writes with a nonzero upper address field are dropped and flagged.
module reg_bank #(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] SP_RESET = 32'd227
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [31:0] write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    input  logic        load_ab,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        addr_err
);

    logic [31:0] regs [NUM_REGS];
    logic        wr_hi_bad;
    logic        wr_valid;
    logic [4:0]  wr_idx;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;

    assign wr_idx    = write_reg[4:0];
    assign wr_hi_bad = |write_reg[31:5];
    // Only writes that will actually land are allowed to forward.
    assign wr_valid  = reg_write && !wr_hi_bad && (wr_idx != 5'd0);

    always_comb begin
        opnd_a = regs[read_reg1];
        if (read_reg1 == 5'd0)
            opnd_a = 32'd0;
        else if (wr_valid && (wr_idx == read_reg1))
            opnd_a = write_data;
    end

    always_comb begin
        opnd_b = regs[read_reg2];
        if (read_reg2 == 5'd0)
            opnd_b = 32'd0;
        else if (wr_valid && (wr_idx == read_reg2))
            opnd_b = write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == 29) ? SP_RESET : 32'd0;
            a_out    <= 32'd0;
            b_out    <= 32'd0;
            addr_err <= 1'b0;
        end else begin
            if (wr_valid)
                regs[wr_idx] <= write_data;
            if (load_ab) begin
                a_out <= opnd_a;
                b_out <= opnd_b;
            end
            if (reg_write && wr_hi_bad)
                addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a reference model computes expected
// operands per edge, queues them, and compares after the edge.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [31:0] write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        load_ab;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        addr_err;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        e;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mreg [32];
    logic [31:0] ma, mb;
    logic        merr;

    reg_bank #(.NUM_REGS(32), .SP_RESET(32'd227)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .load_ab    (load_ab),
        .a_out      (a_out),
        .b_out      (b_out),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mreg[29] = 32'd227;
        ma = 32'd0;
        mb = 32'd0;
        merr = 1'b0;
    endtask

    function automatic logic [31:0] mval(input logic [4:0] r, input logic vw,
                                         input logic [4:0] widx, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (vw && widx == r) return wd;
        return mreg[r];
    endfunction

    task automatic step(input string tag, input logic rw, input logic [31:0] wr,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic lab);
        exp_t e;
        logic vw;
        @(negedge clk);
        reg_write  = rw;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        load_ab    = lab;
        vw = rw && (wr[31:5] == 27'd0) && (wr[4:0] != 5'd0);
        if (lab) begin
            ma = mval(r1, vw, wr[4:0], wd);
            mb = mval(r2, vw, wr[4:0], wd);
        end
        if (rw && (wr[31:5] != 27'd0)) merr = 1'b1;
        if (vw) mreg[wr[4:0]] = wd;
        e.a = ma;
        e.b = mb;
        e.e = merr;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, ".a"}, a_out, e.a);
        check({tag, ".b"}, b_out, e.b);
        check({tag, ".err"}, {31'd0, addr_err}, {31'd0, e.e});
    endtask

    initial begin
        logic [31:0] wr;
        reset = 1'b0;
        reg_write = 1'b0;
        write_reg = 32'd0;
        write_data = 32'd0;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        load_ab = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst.a", a_out, 32'd0);
        check("rst.b", b_out, 32'd0);
        check("rst.err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        step("rd_sp",  1'b0, 32'd0,  32'd0,         5'd29, 5'd5,  1'b1);
        step("wr31",   1'b1, 32'd31, 32'h0000_1234, 5'd0,  5'd0,  1'b0);
        step("rd31",   1'b0, 32'd0,  32'd0,         5'd31, 5'd29, 1'b1);
        step("fwd8",   1'b1, 32'd8,  32'hDEAD_BEEF, 5'd8,  5'd8,  1'b1);
        step("wr0",    1'b1, 32'd0,  32'hFFFF_FFFF, 5'd0,  5'd31, 1'b1);
        step("rd0",    1'b0, 32'd0,  32'd0,         5'd0,  5'd8,  1'b1);
        step("ld3",    1'b1, 32'd3,  32'h0000_0055, 5'd3,  5'd3,  1'b1);
        step("hold3",  1'b1, 32'd3,  32'h0000_0066, 5'd3,  5'd3,  1'b0);
        step("hold3b", 1'b0, 32'd0,  32'd0,         5'd8,  5'd8,  1'b0);
        step("rd3",    1'b0, 32'd0,  32'd0,         5'd3,  5'd8,  1'b1);
        step("bad20",  1'b1, 32'h0000_0020, 32'd7,  5'd0,  5'd31, 1'b1);
        step("rd_bad", 1'b0, 32'd0,  32'd0,         5'd0,  5'd31, 1'b1);
        step("bad28",  1'b1, 32'h0000_0028, 32'd9,  5'd8,  5'd8,  1'b1);
        step("okwr",   1'b1, 32'd12, 32'h0BAD_F00D, 5'd12, 5'd8,  1'b1);
        step("rd12",   1'b0, 32'd0,  32'd0,         5'd12, 5'd3,  1'b1);

        for (int k = 0; k < 48; k++) begin
            wr = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) wr[31:5] = 27'($urandom_range(1, 3));
            step("rand", 1'($urandom_range(0, 1)), wr, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)));
        end

        step("pre_rst", 1'b1, 32'd29, 32'hA5A5_0001, 5'd29, 5'd29, 1'b1);
        step("pre_bad", 1'b1, 32'h0000_0100, 32'd1,  5'd29, 5'd8,  1'b1);

        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 32'd8;
        write_data = 32'h1111_2222;
        read_reg1  = 5'd8;
        read_reg2  = 5'd29;
        load_ab    = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async.a", a_out, 32'd0);
        check("async.b", b_out, 32'd0);
        check("async.err", {31'd0, addr_err}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge.a", a_out, 32'd0);
        check("rst_edge.b", b_out, 32'd0);
        model_reset();
        reg_write = 1'b0;
        load_ab   = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        step("post_sp", 1'b0, 32'd0, 32'd0, 5'd29, 5'd8,  1'b1);
        step("post_rd", 1'b0, 32'd0, 32'd0, 5'd31, 5'd12, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
